sevenseg_display_driver: RTL and testbench
==========================================

Name: sevenseg_display_driver

Overview:
- Multi-digit, active-low seven-segment display driver for the DE10-Lite HEX displays.
- Accepts a binary value through a valid/ready handshake and converts it to per-digit segment patterns.
- Conversion is hexadecimal (direct nibbles) or decimal (sequential double-dabble, one shift per cycle).
- Applies optional leading-zero blanking and overflow dashes, and holds the displayed image until the next accepted value. Sits between status/telemetry logic (e.g. motor speed) and the board HEX pins.

Parameters:
- DIGITS, 6: number of digits driven (1..8).
- DATA_W, 20: width of the input value (4..32).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- value_i  in  DATA_W  binary value to display
- valid_i  in  1  value_i/mode_dec_i/blank_lz_i are valid
- ready_o  out  1  block can accept a new value
- mode_dec_i  in  1  1 = decimal, 0 = hexadecimal
- blank_lz_i  in  1  1 = blank leading zeros
- busy_o  out  1  conversion or commit in progress
- leds_o  out  7*DIGITS  active-low segments; digit n at bits [7n+6:7n]; digit 0 is least significant

Behaviour:
- Clocking and reset:
  - Single clock `clk`; asynchronous active-low reset `rst_n`.
  - Reset values: leds_o all ones (blank), ready_o=1, busy_o=0, FSM=IDLE.
- Segment bit order per digit: bit0=top, bit1=upper-right, bit2=lower-right, bit3=bottom, bit4=lower-left, bit5=upper-left, bit6=middle. 0 = lit.
- Glyphs:
  - Digits: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Letters: A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
  - Special: dash=7'h3F, blank=7'h7F.
- FSM states: IDLE, CONV, COMMIT.
  - IDLE: ready_o=1. On valid_i&ready_o at edge k, latch value_i, mode_dec_i and blank_lz_i. Go to CONV if decimal, else COMMIT.
  - CONV (decimal only): exactly DATA_W cycles. Each cycle, add 3 to every BCD nibble >=5, then shift left one bit, MSB of the value first. The BCD register is 4*DIGITS bits. A sticky overflow flag sets if a 1 is shifted out of the top BCD bit or a nibble correction carries out. After DATA_W cycles, go to COMMIT.
  - COMMIT: build the digit image and register it into leds_o at the exiting edge, then return to IDLE.
- Latency: leds_o changes at edge k+2 in hex mode and at edge k+DATA_W+2 in decimal mode.
- ready_o=0 and busy_o=1 in CONV and COMMIT. valid_i is ignored there; no queuing.
- Hex mode:
  - Digit n = value nibble n, zero-extended.
  - If DATA_W > 4*DIGITS and any bit above 4*DIGITS-1 is set, the value is an overflow.
- Overflow (either mode): all digits show dash.
- Leading-zero blanking (blank_lz=1, no overflow):
  - Digits above the most significant nonzero digit show blank.
  - Digit 0 is never blanked, so value 0 shows "0".
- leds_o holds its value between commits and is glitch-free (registered output only).
- Reset mid-CONV/COMMIT aborts the conversion. leds_o blanks and the FSM returns to IDLE.

Optional Feature:
- Macro: SEVSEG_BLINK_EN.
- When defined:
  - Adds parameter BLINK_DIV (default 25_000_000) and input blink_i (1 bit).
  - A free-running counter, reset to 0, toggles a phase bit every BLINK_DIV cycles; the phase resets to 0 (visible).
  - While blink_i=1 and phase=1, leds_o is forced to all ones. The stored image is unaffected and reappears when the phase returns to 0 or blink_i drops.
- When undefined: no blink_i port, no counter; leds_o is always the stored image.

Test Plan:
- Reset: assert rst_n=0 mid-run -> leds_o=all 7'h7F, ready_o=1, busy_o=0 immediately (asynchronous).
- Hex, value 20'hABCDE, blank_lz=0, accepted at edge k -> at edge k+2, digits 0..5 = 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h40; ready_o high again at k+2.
- Decimal, value 20'd123, blank_lz=1 -> leds_o unchanged through edge k+21. At k+22, digits 0..2 = 7'h30, 7'h24, 7'h79 and digits 3..5 = 7'h7F.
- Decimal overflow: value 20'd1000000 -> all six digits 7'h3F. Boundary: value 20'd999999 -> all digits 7'h10.
- Decimal 0 with blank_lz=1 -> digit0 = 7'h40, others 7'h7F. With blank_lz=0 -> all 7'h40.
- Handshake:
  - Hold valid_i=1 with a new value during CONV -> value ignored, ready_o=0 until COMMIT exits, display shows the first value only.
  - Pulse rst_n low at CONV cycle 10 -> leds_o 7'h7F and FSM in IDLE.

Source files
------------

// File: rtl/sevenseg_display_driver.sv
// sevenseg_display_driver: valid/ready value -> active-low 7-seg image (hex or double-dabble decimal); optional blink under SEVSEG_BLINK_EN
module sevenseg_display_driver #(
   parameter int DIGITS = 6,
   parameter int DATA_W = 20
`ifdef SEVSEG_BLINK_EN
   ,parameter int BLINK_DIV = 25_000_000
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     value_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic                  mode_dec_i,
   input  logic                  blank_lz_i,
   output logic                  busy_o,
`ifdef SEVSEG_BLINK_EN
   input  logic                  blink_i,
`endif
   output logic [7*DIGITS-1:0]   leds_o
);
   localparam int BW = 4 * DIGITS;
   localparam int XW = (DATA_W > BW) ? DATA_W : BW;
   localparam int CW = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

   state_t             state, next;
   logic [DATA_W-1:0]  shreg;
   logic [BW-1:0]      bcd, corr;
   logic [4:0]         nib;
   logic               carry, ovf, blz, fin, lead, accept, conv_done, in_ovf;
   logic [CW-1:0]      cnt;
   logic [XW-1:0]      wide_in;
   logic [7*DIGITS-1:0] glyphs, pre, img;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   assign accept    = valid_i & ready_o;
   assign conv_done = (state == CONV) && (cnt == CW'(DATA_W - 1));
   assign wide_in   = XW'(value_i);
   // hex values wider than the display cannot be shown; any bit above the digit field flags overflow
   assign in_ovf    = |(wide_in >> BW);

   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= next;

   // next state: hex skips CONV; COMMIT spends two cycles (build image, then publish it)
   always_comb
      next = (state == IDLE) ? (accept ? (mode_dec_i ? CONV : COMMIT) : IDLE)
           : (state == CONV) ? (conv_done ? COMMIT : CONV)
           : (fin ? IDLE : COMMIT);

   // handshake outputs straight from state
   always_comb begin
      ready_o = (state == IDLE);
      busy_o  = (state != IDLE);
   end

   // add-3 correction of every BCD nibble before the shift; a nibble carry means the digit field overflowed
   always_comb begin
      corr  = '0;
      carry = 1'b0;
      nib   = '0;
      for (int i = 0; i < DIGITS; i++) begin
         nib = {1'b0, bcd[4*i+:4]} + ((bcd[4*i+:4] >= 4'd5) ? 5'd3 : 5'd0);
         corr[4*i+:4] = nib[3:0];
         carry = carry | nib[4];
      end
   end

   // capture on accept; hex nibbles load the digit register directly, decimal shifts one value bit per CONV cycle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         shreg <= '0;
         bcd   <= '0;
         ovf   <= 1'b0;
         blz   <= 1'b0;
         cnt   <= '0;
      end else if (accept) begin
         shreg <= value_i;
         bcd   <= mode_dec_i ? '0 : wide_in[BW-1:0];
         ovf   <= mode_dec_i ? 1'b0 : in_ovf;
         blz   <= blank_lz_i;
         cnt   <= '0;
      end else if (state == CONV) begin
         shreg <= shreg << 1;
         bcd   <= {corr[BW-2:0], shreg[DATA_W-1]};
         ovf   <= ovf | carry | corr[BW-1];
         cnt   <= cnt + 1'b1;
      end

   // digit image: dashes on overflow, otherwise glyphs with leading zeros blanked above digit 0
   always_comb begin
      lead   = 1'b1;
      glyphs = '1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         lead = lead & (bcd[4*i+:4] == 4'd0);
         glyphs[7*i+:7] = ovf ? 7'h3F : (blz && lead && i != 0) ? 7'h7F : glyph(bcd[4*i+:4]);
      end
   end

   // first COMMIT cycle registers the built image, second publishes it so the pins only ever see flops
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         fin <= 1'b0;
         pre <= '1;
         img <= '1;
      end else begin
         fin <= (state == COMMIT) & ~fin;
         if (state == COMMIT && !fin) pre <= glyphs;
         if (state == COMMIT && fin)  img <= pre;
      end

`ifdef SEVSEG_BLINK_EN
   localparam int DW = ($clog2(BLINK_DIV) > 0) ? $clog2(BLINK_DIV) : 1;
   logic [DW-1:0] div;
   logic          phase, hide;

   // free-running blink divider; hide is registered so the blanking edge is glitch-free
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         div   <= '0;
         phase <= 1'b0;
         hide  <= 1'b0;
      end else begin
         div  <= (div == DW'(BLINK_DIV - 1)) ? '0 : div + 1'b1;
         if (div == DW'(BLINK_DIV - 1)) phase <= ~phase;
         hide <= blink_i & phase;
      end

   assign leds_o = img | {7*DIGITS{hide}};
`else
   assign leds_o = img;
`endif
endmodule

// File: tb/tb_sevenseg_display_driver.sv
// tb_sevenseg_display_driver: randomized and directed checks against an arithmetic display model
module tb_sevenseg_display_driver;
   localparam int DIGITS = 6;
   localparam int DATA_W = 20;
   localparam int IW = 7 * DIGITS;
   localparam logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [DATA_W-1:0] value_i = '0;
   logic              valid_i = 1'b0;
   logic              ready_o;
   logic              mode_dec_i = 1'b0;
   logic              blank_lz_i = 1'b0;
   logic              busy_o;
   logic [IW-1:0]     leds_o;

   int checks = 0;
   int failures = 0;

   sevenseg_display_driver #(.DIGITS(DIGITS), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n), .value_i(value_i), .valid_i(valid_i), .ready_o(ready_o),
      .mode_dec_i(mode_dec_i), .blank_lz_i(blank_lz_i), .busy_o(busy_o), .leds_o(leds_o));

   always #5 clk = ~clk;

   // expected image from plain arithmetic: base-10 or base-16 digits of the value
   function automatic logic [IW-1:0] model(input logic [DATA_W-1:0] v, input logic dec, input logic blz);
      int d [DIGITS];
      int top = 0;
      longint p = 1;
      logic ovf = dec && (v >= 20'd1000000);
      logic [IW-1:0] r;
      for (int i = 0; i < DIGITS; i++) begin
         d[i] = dec ? int'((longint'(v) / p) % 10) : int'((v >> (4 * i)) & 20'hF);
         p = p * 10;
         if (d[i] != 0) top = i;
      end
      for (int i = 0; i < DIGITS; i++)
         r[7*i+:7] = ovf ? 7'h3F : (blz && i > top) ? 7'h7F : GLY[d[i]];
      return r;
   endfunction

   // present one value and return just after the accepting edge
   task automatic apply(input logic [DATA_W-1:0] v, input logic dec, input logic blz);
      int n = 0;
      @(negedge clk);
      while (!ready_o && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!ready_o) begin
         checks++;
         failures++;
         $display("FAIL ready_wait: ready_o=%0b required 1 within 60 cycles", ready_o);
      end
      value_i = v;
      mode_dec_i = dec;
      blank_lz_i = blz;
      valid_i = 1'b1;
      @(posedge clk);
      #1 valid_i = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      checks++;
      if (leds_o !== {IW{1'b1}} || ready_o !== 1'b1 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL reset: leds=%h ready=%b busy=%b required leds=%h ready=1 busy=0", leds_o, ready_o, busy_o, {IW{1'b1}});
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (leds_o !== {IW{1'b1}} || ready_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_hold: leds=%h ready=%b required all ones, ready=1", leds_o, ready_o);
      end
   endtask

   task automatic test_hex_latency;
      logic [IW-1:0] prev = leds_o;
      apply(20'hABCDE, 1'b0, 1'b0);
      checks++;
      if (ready_o !== 1'b0 || busy_o !== 1'b1 || leds_o !== prev) begin
         failures++;
         $display("FAIL hex_k: ready=%b busy=%b leds=%h required 0 1 %h", ready_o, busy_o, leds_o, prev);
      end
      @(posedge clk) #1;
      checks++;
      if (leds_o !== prev) begin
         failures++;
         $display("FAIL hex_k1: leds=%h required %h", leds_o, prev);
      end
      @(posedge clk) #1;
      checks++;
      if (leds_o !== {7'h40, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06} || ready_o !== 1'b1) begin
         failures++;
         $display("FAIL hex_k2: leds=%h ready=%b required %h ready=1", leds_o, ready_o, {7'h40, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06});
      end
   endtask

   task automatic test_dec_latency;
      logic [IW-1:0] prev = leds_o;
      int bad = 0;
      apply(20'd123, 1'b1, 1'b1);
      for (int e = 1; e <= DATA_W + 1; e++) begin
         @(posedge clk) #1;
         if (leds_o !== prev || ready_o !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL dec_hold: %0d cycles changed/ready early, required 0", bad);
      end
      @(posedge clk) #1;
      checks++;
      if (leds_o !== {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30} || ready_o !== 1'b1) begin
         failures++;
         $display("FAIL dec_123: leds=%h ready=%b required %h ready=1", leds_o, ready_o, {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30});
      end
   endtask

   task automatic test_boundaries;
      logic [DATA_W-1:0] vals [4] = '{20'd1000000, 20'd999999, 20'd0, 20'd0};
      logic              blzs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [IW-1:0]     req  [4] = '{{DIGITS{7'h3F}}, {DIGITS{7'h10}},
                                     {{(DIGITS-1){7'h7F}}, 7'h40}, {DIGITS{7'h40}}};
      for (int i = 0; i < 4; i++) begin
         apply(vals[i], 1'b1, blzs[i]);
         repeat (DATA_W + 2) @(posedge clk);
         #1;
         checks++;
         if (leds_o !== req[i]) begin
            failures++;
            $display("FAIL boundary_%0d: value=%0d leds=%h required %h", i, vals[i], leds_o, req[i]);
         end
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         logic dec = 1'($urandom_range(0, 1));
         logic blz = 1'($urandom_range(0, 1));
         logic [DATA_W-1:0] v;
         case ($urandom_range(0, 3))
            0:       v = DATA_W'($urandom_range(0, 99));
            1:       v = DATA_W'($urandom_range(0, 4095));
            default: v = DATA_W'($urandom_range(0, 1048575));
         endcase
         apply(v, dec, blz);
         repeat (dec ? DATA_W + 2 : 2) @(posedge clk);
         #1;
         checks++;
         if (leds_o !== model(v, dec, blz) || ready_o !== 1'b1) begin
            failures++;
            $display("FAIL random_%0d: v=%h dec=%b blz=%b leds=%h ready=%b required %h", i, v, dec, blz, leds_o, ready_o, model(v, dec, blz));
         end
      end
   endtask

   task automatic test_back_to_back;
      int bad = 0;
      apply(20'd4321, 1'b1, 1'b0);
      value_i = 20'd777;
      mode_dec_i = 1'b0;
      valid_i = 1'b1;
      for (int e = 1; e <= DATA_W + 1; e++) begin
         @(posedge clk) #1;
         if (ready_o !== 1'b0 || busy_o !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL b2b_ready: %0d busy cycles with ready high, required 0", bad);
      end
      @(posedge clk) #1;
      checks++;
      if (leds_o !== model(20'd4321, 1'b1, 1'b0) || ready_o !== 1'b1) begin
         failures++;
         $display("FAIL b2b_image: leds=%h ready=%b required %h ready=1", leds_o, ready_o, model(20'd4321, 1'b1, 1'b0));
      end
      valid_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_midconv;
      apply(20'd55555, 1'b1, 1'b0);
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (leds_o !== {IW{1'b1}} || ready_o !== 1'b1 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_conv: leds=%h ready=%b busy=%b required all ones 1 0", leds_o, ready_o, busy_o);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (DATA_W + 4) @(negedge clk);
      checks++;
      if (leds_o !== {IW{1'b1}} || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_abort: leds=%h busy=%b required all ones 0", leds_o, busy_o);
      end
      apply(20'h00F0, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (leds_o !== model(20'h00F0, 1'b0, 1'b1)) begin
         failures++;
         $display("FAIL post_reset: leds=%h required %h", leds_o, model(20'h00F0, 1'b0, 1'b1));
      end
   endtask

   initial begin
      test_reset;
      test_hex_latency;
      test_dec_latency;
      test_boundaries;
      test_random;
      test_back_to_back;
      test_reset_midconv;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
